// File: rtl/jtframe_db15_pkg.sv
// Shared types and constants for the DB15 arcade-stick adapter reader.
package jtframe_db15_pkg;

  // Poll sequencer states. Explicit encodings keep the state register
  // readable in waveforms and stable across tool versions.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    CHECK = 3'd4
  } db15_st_t;

  // Number of clk_sys cycles left in the JOY_CLK low half (including the
  // sampling cycle) when a bit is captured. This leaves room for the
  // synchroniser latency and still lands before the rising edge.
  localparam int SAMPLE_AT = 3;

  // Serial bits that belong to one player.
  localparam int P1_BITS = 12;

  // Widens one player's 12 button/direction bits into a 16-bit joystick word.
  function automatic logic [15:0] joy_word(input logic [P1_BITS-1:0] bits);
    return {4'b0000, bits};
  endfunction

endpackage

// File: rtl/jtframe_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module jtframe_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/jtframe_db15_reader.sv
// Polls a 74HC165 DB15 adapter chain, reads CHAIN_BITS serial bits per frame
// and publishes the two joystick words once two consecutive frames agree.
// Player 1 uses serial bits [11:0], player 2 uses bits [23:12].
module jtframe_db15_reader
  import jtframe_db15_pkg::*;
#(
  parameter int CLK_DIV    = 24,
  parameter int POLL_GAP   = 48000,
  parameter int CHAIN_BITS = 24
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        enable,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  input  logic        JOY_DATA,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [TW-1:0] TMR_RELOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_SAMPLE = TW'(SAMPLE_AT - 1);
  localparam logic [TW-1:0] TMR_ZERO   = {TW{1'b0}};
  localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);
  localparam logic [GW-1:0] GAP_ZERO   = {GW{1'b0}};
  localparam logic [4:0]    BIT_LAST   = 5'(CHAIN_BITS - 1);

  db15_st_t              st_r;
  logic [TW-1:0]         timer_r;
  logic [GW-1:0]         gap_r;
  logic [4:0]            bit_r;
  logic [CHAIN_BITS-1:0] shreg_r;
  logic [CHAIN_BITS-1:0] prev_r;
  logic                  prev_ok_r;
  logic                  joy_clk_r;
  logic                  joy_load_r;
  logic [15:0]           joy1_r;
  logic [15:0]           joy2_r;
  logic                  done_r;

  logic                  data_sync_s;
  logic                  timer_run_s;
  logic                  tick_s;
  logic                  sample_s;

  jtframe_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .d     (JOY_DATA),
    .q     (data_sync_s)
  );

  // Half-period timer enable, end-of-half-period tick and bit sample strobe.
  always_comb begin
    timer_run_s = 1'b0;
    case (st_r)
      LOAD, LOW, HIGH: timer_run_s = 1'b1;
      default:         timer_run_s = 1'b0;
    endcase
    tick_s   = timer_run_s && (timer_r == TMR_ZERO);
    sample_s = (st_r == LOW) && (timer_r == TMR_SAMPLE);
  end

  // Half-period timer: parked at its reload value outside the shift phases
  // so every LOAD starts a full half-period.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= TMR_RELOAD;
    end else if (!timer_run_s || tick_s) begin
      timer_r <= TMR_RELOAD;
    end else begin
      timer_r <= timer_r - TW'(1);
    end
  end

  // Poll sequencer: gap timing, load strobe, shift clock and bit counter.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      st_r       <= IDLE;
      gap_r      <= GAP_ZERO;
      bit_r      <= 5'd0;
      joy_clk_r  <= 1'b1;
      joy_load_r <= 1'b1;
    end else begin
      case (st_r)
        IDLE: begin
          // Holding the gap at zero while disabled makes a re-enable
          // always wait a full gap before the next load.
          if (!enable) begin
            gap_r <= GAP_ZERO;
          end else if (gap_r == GAP_LAST) begin
            gap_r      <= GAP_ZERO;
            joy_load_r <= 1'b0;
            st_r       <= LOAD;
          end else begin
            gap_r <= gap_r + GW'(1);
          end
        end
        LOAD: begin
          if (tick_s) begin
            joy_load_r <= 1'b1;
            joy_clk_r  <= 1'b0;
            bit_r      <= 5'd0;
            st_r       <= LOW;
          end
        end
        LOW: begin
          if (tick_s) begin
            joy_clk_r <= 1'b1;
            st_r      <= HIGH;
          end
        end
        HIGH: begin
          if (tick_s) begin
            if (bit_r == BIT_LAST) begin
              st_r <= CHECK;
            end else begin
              bit_r     <= bit_r + 5'd1;
              joy_clk_r <= 1'b0;
              st_r      <= LOW;
            end
          end
        end
        CHECK: begin
          st_r <= IDLE;
        end
        default: begin
          st_r       <= IDLE;
          gap_r      <= GAP_ZERO;
          bit_r      <= 5'd0;
          joy_clk_r  <= 1'b1;
          joy_load_r <= 1'b1;
        end
      endcase
    end
  end

  // Shift register: captures the current bit (inverted, inputs are active
  // low) once per JOY_CLK low half.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= {CHAIN_BITS{1'b0}};
    end else if (sample_s) begin
      shreg_r[bit_r] <= ~data_sync_s;
    end
  end

  // Glitch filter: publish a frame only when it equals the previous one.
  // History is dropped while idle and disabled, so after a re-enable two
  // fresh frames are needed before the outputs move again.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      prev_r    <= {CHAIN_BITS{1'b0}};
      prev_ok_r <= 1'b0;
      joy1_r    <= 16'h0000;
      joy2_r    <= 16'h0000;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (st_r == CHECK) begin
        prev_r    <= shreg_r;
        prev_ok_r <= 1'b1;
        if (prev_ok_r && (shreg_r == prev_r)) begin
          joy1_r <= joy_word(shreg_r[P1_BITS-1:0]);
          joy2_r <= joy_word(shreg_r[2*P1_BITS-1:P1_BITS]);
          done_r <= 1'b1;
        end
      end else if ((st_r == IDLE) && !enable) begin
        prev_ok_r <= 1'b0;
      end
    end
  end

  assign JOY_CLK    = joy_clk_r;
  assign JOY_LOAD   = joy_load_r;
  assign joystick1  = joy1_r;
  assign joystick2  = joy2_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_jtframe_db15_reader.sv
// Self-checking bench: a 74HC165 chain model feeds the reader, a word-level
// reference decides which frames must be published, and a monitor checks
// every frame_done against the queued expectation.
module tb_jtframe_db15_reader;

  localparam int CLK_DIV    = 4;
  localparam int POLL_GAP   = 16;
  localparam int CHAIN_BITS = 24;

  logic        clk_sys  = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable   = 1'b0;
  logic        JOY_DATA = 1'b1;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        frame_done;
  logic [15:0] joystick1;
  logic [15:0] joystick2;

  int total = 0;
  int bad   = 0;

  // Scoreboard: {joystick2, joystick1} expected at each frame_done.
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  // Stimulus word presented by the adapter (bit=1 means pressed).
  logic [23:0] cur_word    = 24'h0;
  logic        glitch_mode = 1'b0;

  // Adapter model and frame tracking state.
  logic        prev_clk  = 1'b1;
  logic        prev_load = 1'b1;
  logic [23:0] latch     = 24'h0;
  logic [23:0] hist      = 24'h0;
  logic        hist_ok   = 1'b0;
  logic        track_ok  = 1'b0;
  int rises = 0, lows = 0, load_len = 0, low_cyc = 0, post = 0;
  int frame_ends = 0, done_cnt = 0;
  logic [15:0] last_j1 = 16'h0, last_j2 = 16'h0;

  jtframe_db15_reader #(
    .CLK_DIV    (CLK_DIV),
    .POLL_GAP   (POLL_GAP),
    .CHAIN_BITS (CHAIN_BITS)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .enable     (enable),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_DATA   (JOY_DATA),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expect_of(input logic [23:0] w);
    return {4'h0, w[23:12], 4'h0, w[11:0]};
  endfunction

  // 74HC165 model plus frame bookkeeping, evaluated mid-cycle.
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      prev_clk = 1'b1; prev_load = 1'b1; hist_ok = 1'b0; track_ok = 1'b0;
      rises = 0; lows = 0; load_len = 0; low_cyc = 0; post = 0;
      JOY_DATA = 1'b1;
    end else begin
      if (!JOY_LOAD) begin
        if (prev_load) begin
          if (track_ok) check("low_phases", lows, CHAIN_BITS);
          track_ok = 1'b1; lows = 0; rises = 0; post = 0; load_len = 1;
          // Reference rule: a frame is published when it equals the previous one.
          if (hist_ok && cur_word == hist) exp_q.push_back(expect_of(cur_word));
          hist = cur_word; hist_ok = 1'b1;
        end else begin
          load_len++;
        end
        latch = hist;
      end else begin
        if (!prev_load) check("load_len", load_len, CLK_DIV);
        if (!JOY_CLK && prev_clk) lows++;
        if (JOY_CLK && !prev_clk) begin
          rises++;
          latch = latch >> 1;
          if (rises == CHAIN_BITS) post = 1;
        end else if (post > 0) begin
          post++;
          if (post == CLK_DIV + 2) begin
            frame_ends++;
            post = 0;
          end
        end
      end
      low_cyc  = (!JOY_CLK && JOY_LOAD) ? low_cyc + 1 : 0;
      JOY_DATA = ~latch[0] ^ (glitch_mode && low_cyc == CLK_DIV);
      prev_clk = JOY_CLK; prev_load = JOY_LOAD;
    end
  end

  // Monitor: pops an expectation on every frame_done, otherwise outputs hold.
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      check("rst_outputs", {frame_done, joystick2, joystick1}, 33'h0);
      last_j1 = 16'h0; last_j2 = 16'h0;
    end else if (frame_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got j1=%0h j2=%0h expected no frame_done", joystick1, joystick2);
      end else begin
        mon_e = exp_q.pop_front();
        check("joystick1", joystick1, mon_e[15:0]);
        check("joystick2", joystick2, mon_e[31:16]);
      end
      last_j1 = joystick1; last_j2 = joystick2;
    end else begin
      check("stable_outputs", {joystick2, joystick1}, {last_j2, last_j1});
    end
  end

  task automatic wait_frames(input int n);
    int target = frame_ends + n;
    int budget = n * (2 * CLK_DIV * CHAIN_BITS + 2 * CLK_DIV + POLL_GAP + 60);
    while (frame_ends < target && budget > 0) begin
      @(negedge clk_sys);
      budget--;
    end
    if (frame_ends < target) begin
      total++; bad++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frame_ends, target);
    end
    @(negedge clk_sys);
  endtask

  task automatic wait_bit(input int r, input logic lvl);
    int budget = 600;
    do begin
      @(negedge clk_sys);
      budget--;
    end while (!(rises == r && JOY_CLK == lvl) && budget > 0);
    if (budget == 0) begin
      total++; bad++;
      $display("FAIL bit_timeout: got rises=%0d expected %0d", rises, r);
    end
  endtask

  initial begin
    int d0;
    int activity;
    logic [23:0] w;
    enable = 1'b1;
    repeat (4) @(negedge clk_sys);
    check("reset_joy1", joystick1, 32'h0);
    check("reset_joy2", joystick2, 32'h0);
    check("reset_done", frame_done, 32'h0);
    check("reset_joy_clk", JOY_CLK, 32'h1);
    check("reset_joy_load", JOY_LOAD, 32'h1);
    #2 rst_n = 1'b1;

    // All released: only the second frame is published.
    d0 = done_cnt;
    wait_frames(1);
    check("t1_first_frame_done", done_cnt - d0, 32'd0);
    wait_frames(1);
    check("t1_done_count", done_cnt - d0, 32'd1);
    check("t1_joy1", joystick1, 32'h0);

    // Word 800_001.
    cur_word = 24'h800001; d0 = done_cnt;
    wait_frames(2);
    check("t2_done_count", done_cnt - d0, 32'd1);
    check("t2_joy1", joystick1, 32'h0001);
    check("t2_joy2", joystick2, 32'h0800);

    // A then B then B.
    cur_word = 24'h00000F; wait_frames(1);
    cur_word = 24'h0000F0; d0 = done_cnt; wait_frames(1);
    check("t3_ab_done", done_cnt - d0, 32'd0);
    wait_frames(1);
    check("t3_bb_done", done_cnt - d0, 32'd1);
    check("t3_joy1", joystick1, 32'h00F0);

    // Random words held for one or two frames.
    for (int i = 0; i < 8; i++) begin
      w = 24'($urandom());
      cur_word = w;
      wait_frames(int'($urandom_range(2, 1)));
    end

    // Enable dropped during bit 10.
    cur_word = 24'h123456; wait_frames(2);
    wait_bit(10, 1'b0);
    enable = 1'b0;
    wait_frames(1);
    hist_ok = 1'b0;
    d0 = done_cnt; activity = 0;
    repeat (10 * POLL_GAP) begin
      @(negedge clk_sys);
      if (!JOY_LOAD || !JOY_CLK) activity++;
    end
    check("t4_idle_pins", activity, 32'd0);
    check("t4_idle_done", done_cnt - d0, 32'd0);
    enable = 1'b1; d0 = done_cnt;
    wait_frames(1);
    check("t4_first_frame_done", done_cnt - d0, 32'd0);
    wait_frames(1);
    check("t4_second_frame_done", done_cnt - d0, 32'd1);

    // Data glitch in the last low cycle before every rising edge.
    glitch_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur_word = 24'($urandom()); wait_frames(2);
    end
    cur_word = 24'h5A53C3; wait_frames(2);
    check("t6_joy1", joystick1, 32'h03C3);
    check("t6_joy2", joystick2, 32'h05A5);
    glitch_mode = 1'b0;

    // Reset during the high phase of bit 15.
    wait_bit(16, 1'b1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_joy_clk", JOY_CLK, 32'h1);
    check("t5_joy_load", JOY_LOAD, 32'h1);
    check("t5_joy1", joystick1, 32'h0);
    check("t5_joy2", joystick2, 32'h0);
    repeat (3) @(negedge clk_sys);
    #2 rst_n = 1'b1;
    d0 = done_cnt;
    wait_frames(1);
    check("t5_first_frame_done", done_cnt - d0, 32'd0);
    wait_frames(1);
    check("t5_second_frame_done", done_cnt - d0, 32'd1);
    check("t5_joy1_after", joystick1, 32'h03C3);

    repeat (5) @(negedge clk_sys);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
